// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage program counter.
// It handles stall, branch/jump redirect, a circular return-address stack,
// halt/resume control and a sticky watch-address flag for board debug.
module pc_fetch_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int unsigned      RAS_DEPTH  = 4,
    parameter logic [WIDTH-1:0] WATCH_ADDR = WIDTH'(32'h10)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             BranchE,
    input  logic [WIDTH-1:0] BranchTargetE,
    input  logic             CallE,
    input  logic [WIDTH-1:0] RetAddrE,
    input  logic             RetE,
    input  logic             Halt,
    input  logic             Resume,
    output logic [WIDTH-1:0] q,
    output logic             ValidF,
    output logic [1:0]       State,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasOverflow,
    output logic             RasUnderflow,
    output logic             WatchHit
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] q_d;
    logic             push;
    logic             pop;
    logic             underflow_set;
    logic             watch_set;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty_c;
    logic             ras_full_c;

    // The stack top is the most recent write, one slot below the write pointer.
    assign ras_top     = ras_mem[wr_ptr - PTR_W'(1)];
    assign ras_empty_c = (ras_cnt == '0);
    assign ras_full_c  = (ras_cnt == CNT_FULL);

    assign ValidF   = (state_q == RUN);
    assign State    = state_q;
    assign RasEmpty = ras_empty_c;
    assign RasFull  = ras_full_c;

    // Hold the control-state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Compute the next state, the next PC and the stack operations.
    // The priority order is branch, then return, then stall, then increment.
    always_comb begin
        state_d       = state_q;
        q_d           = q;
        push          = 1'b0;
        pop           = 1'b0;
        underflow_set = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (BranchE) begin
                    q_d  = BranchTargetE;
                    push = CallE;
                end else if (RetE && !ras_empty_c) begin
                    q_d = ras_top;
                    pop = 1'b1;
                end else begin
                    underflow_set = RetE;
                    if (!StallF) begin
                        q_d = q + WIDTH'(STEP);
                    end
                end
                if (Halt) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (Resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        watch_set = (state_q == RUN) && (q_d == WATCH_ADDR);
    end

    // Hold the PC register and the sticky watch and underflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q            <= RESET_VEC;
            WatchHit     <= 1'b0;
            RasUnderflow <= 1'b0;
        end else begin
            q <= q_d;
            if (watch_set) begin
                WatchHit <= 1'b1;
            end
            if (underflow_set) begin
                RasUnderflow <= 1'b1;
            end
        end
    end

    // Circular return stack: a push while full overwrites the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_mem     <= '{default: '0};
            wr_ptr      <= '0;
            ras_cnt     <= '0;
            RasOverflow <= 1'b0;
        end else if (push) begin
            ras_mem[wr_ptr] <= RetAddrE;
            wr_ptr          <= wr_ptr + PTR_W'(1);
            if (ras_full_c) begin
                RasOverflow <= 1'b1;
            end else begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (pop) begin
            wr_ptr  <= wr_ptr - PTR_W'(1);
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic.
// The outputs are checked against a queue-based reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, BranchE, CallE, RetE, Halt, Resume;
    logic [31:0] BranchTargetE, RetAddrE;
    logic [31:0] q;
    logic        ValidF;
    logic [1:0]  State;
    logic        RasEmpty, RasFull, RasOverflow, RasUnderflow, WatchHit;

    pc_fetch_unit #(
        .WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .RAS_DEPTH(4), .WATCH_ADDR(32'h10)
    ) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .BranchE(BranchE),
        .BranchTargetE(BranchTargetE), .CallE(CallE), .RetAddrE(RetAddrE),
        .RetE(RetE), .Halt(Halt), .Resume(Resume), .q(q), .ValidF(ValidF),
        .State(State), .RasEmpty(RasEmpty), .RasFull(RasFull),
        .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow), .WatchHit(WatchHit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 boot, 1 run, 2 halt; stack as a queue (back = top)
    int          m_state;
    logic [31:0] m_q;
    logic [31:0] m_ras[$];
    bit          m_ovf, m_unf, m_watch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q     = 32'h0;
        m_ras.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_watch = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] nq;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            nq = m_q;
            if (BranchE) begin
                nq = BranchTargetE;
                if (CallE) begin
                    if (m_ras.size() == 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back(RetAddrE);
                end
            end else if (RetE && m_ras.size() > 0) begin
                nq = m_ras.pop_back();
            end else begin
                if (RetE) m_unf = 1'b1;
                if (!StallF) nq = m_q + 32'd4;
            end
            if (nq == 32'h10) m_watch = 1'b1;
            m_q = nq;
            if (Halt) m_state = 2;
        end else begin
            if (Resume) m_state = 1;
        end
    endtask

    task automatic check_all();
        chk("q", q, m_q);
        chk("State", 32'(State), 32'(m_state));
        chk("ValidF", 32'(ValidF), 32'(m_state == 1));
        chk("RasEmpty", 32'(RasEmpty), 32'(m_ras.size() == 0));
        chk("RasFull", 32'(RasFull), 32'(m_ras.size() == 4));
        chk("RasOverflow", 32'(RasOverflow), 32'(m_ovf));
        chk("RasUnderflow", 32'(RasUnderflow), 32'(m_unf));
        chk("WatchHit", 32'(WatchHit), 32'(m_watch));
    endtask

    task automatic idle();
        StallF = 0; BranchE = 0; CallE = 0; RetE = 0; Halt = 0; Resume = 0;
        BranchTargetE = 32'h0; RetAddrE = 32'h0;
    endtask

    // The model advances on every edge; outputs are checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Assert reset mid-cycle, check at once, and release just after an edge.
    task automatic do_reset();
        #3;
        idle();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] exp_pop [4];

    initial begin
        idle();
        reset = 1'b0;
        exp_pop[0] = 32'h50; exp_pop[1] = 32'h40; exp_pop[2] = 32'h30; exp_pop[3] = 32'h20;

        // Boot sequence and the watch address
        do_reset();
        chk("boot_state", 32'(State), 32'd0);
        chk("boot_valid", 32'(ValidF), 32'd0);
        tick();
        chk("run_q0", q, 32'h0);
        chk("run_valid", 32'(ValidF), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("watch_q", q, 32'h10);
        chk("watch_hit", 32'(WatchHit), 32'd1);

        // Stall at 8, then a branch that overrides the stall
        do_reset();
        tick(); tick(); tick();
        chk("pre_stall_q", q, 32'h8);
        StallF = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_q", q, 32'h8);
        BranchE = 1; BranchTargetE = 32'h100;
        tick();
        chk("branch_over_stall", q, 32'h100);
        idle();

        // Call followed by a return
        BranchE = 1; CallE = 1; BranchTargetE = 32'h200; RetAddrE = 32'h40;
        tick();
        chk("call_q", q, 32'h200);
        idle();
        tick();
        RetE = 1;
        tick();
        chk("ret_q", q, 32'h40);
        chk("ret_empty", 32'(RasEmpty), 32'd1);
        idle();

        // Overflow the stack, then drain it and underflow it
        for (int i = 1; i <= 5; i++) begin
            BranchE = 1; CallE = 1; BranchTargetE = 32'h1000; RetAddrE = 32'(i * 16);
            tick();
        end
        idle();
        chk("ovf_full", 32'(RasFull), 32'd1);
        chk("ovf_flag", 32'(RasOverflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            RetE = 1;
            tick();
            chk("pop_order", q, exp_pop[i]);
        end
        tick();
        chk("unf_flag", 32'(RasUnderflow), 32'd1);
        chk("unf_no_redirect", q, 32'h24);
        idle();

        // Halt at q=8 and resume
        do_reset();
        tick(); tick(); tick();
        Halt = 1;
        tick();
        chk("halt_q", q, 32'hC);
        chk("halt_state", 32'(State), 32'd2);
        Halt = 0; BranchE = 1; BranchTargetE = 32'h300;
        for (int i = 0; i < 3; i++) tick();
        chk("halt_frozen", q, 32'hC);
        chk("halt_invalid", 32'(ValidF), 32'd0);
        idle();
        Resume = 1;
        tick();
        chk("resume_q", q, 32'hC);
        chk("resume_state", 32'(State), 32'd1);
        Resume = 0;
        tick();
        chk("resume_next", q, 32'h10);

        // Fill the stack, halt, then apply an async reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            BranchE = 1; CallE = 1; BranchTargetE = 32'h500; RetAddrE = 32'h600;
            tick();
        end
        idle();
        Halt = 1;
        tick();
        idle();
        chk("pre_reset_full", 32'(RasFull), 32'd1);
        do_reset();
        chk("rst_q", q, 32'h0);
        chk("rst_empty", 32'(RasEmpty), 32'd1);
        chk("rst_watch", 32'(WatchHit), 32'd0);

        // PC wraps around from the top of the address space
        tick();
        BranchE = 1; BranchTargetE = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        chk("wrap_q", q, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                BranchE       = ($urandom_range(0, 99) < 15);
                CallE         = $urandom_range(0, 1) == 1;
                RetE          = ($urandom_range(0, 99) < 20);
                StallF        = ($urandom_range(0, 99) < 20);
                Halt          = ($urandom_range(0, 99) < 3);
                Resume        = ($urandom_range(0, 99) < 25);
                BranchTargetE = ($urandom_range(0, 3) == 0) ? 32'h10 : ($urandom() & 32'hFFFF_FFFC);
                RetAddrE      = ($urandom_range(0, 3) == 0) ? 32'hC : $urandom();
                tick();
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised fetch-stage program counter for the pipelined core, with stall, branch/jump redirect, a return-address stack (RAS), a halt/resume controller and a sticky watch-address flag for board debug. Sits at the head of the IF stage: drives the instruction-memory address and takes redirect and stall controls from the execute stage and the hazard unit. Generalises the plain PC flip-flop to configurable width, step, reset vector and RAS depth.

## Interface
- WIDTH, 32, PC width in bits (≥ 8)
- STEP, 4, sequential increment added to the PC each advancing cycle
- RESET_VEC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)
- WATCH_ADDR, 'h10, address that sets the sticky WatchHit flag
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- StallF  in  1  hold PC this cycle
- BranchE  in  1  redirect to BranchTargetE
- BranchTargetE  in  WIDTH  redirect target
- CallE  in  1  push RetAddrE onto RAS (qualified by BranchE)
- RetAddrE  in  WIDTH  return address to push
- RetE  in  1  redirect to RAS top and pop
- Halt  in  1  request halt
- Resume  in  1  leave halt
- q  out  WIDTH  current fetch PC
- ValidF  out  1  q is a valid fetch address this cycle
- State  out  2  00 BOOT, 01 RUN, 10 HALT
- RasEmpty  out  1  RAS holds no entries
- RasFull  out  1  RAS holds RAS_DEPTH entries
- RasOverflow  out  1  sticky: push while full
- RasUnderflow  out  1  sticky: pop while empty
- WatchHit  out  1  sticky: PC loaded with WATCH_ADDR while in RUN

## Operation
- Reset (async, any time incl. mid-redirect): q=RESET_VEC, State=BOOT, ValidF=0, RAS count 0 (RasEmpty=1, RasFull=0), all sticky flags 0.
- BOOT: q held; first rising edge after reset release moves to RUN; all control inputs ignored.
- RUN, next-PC priority on each edge: (1) BranchE → BranchTargetE; (2) RetE → RAS top; (3) StallF → hold; (4) otherwise q+STEP.
- Redirects (1),(2) override StallF.
- BranchE and RetE together: BranchE wins, RAS not popped.
- CallE only acts with BranchE=1: pushes RetAddrE. CallE without BranchE ignored.
- RetE when RAS empty: no redirect, PC follows rule (3)/(4), RasUnderflow set.
- Push when full: oldest entry overwritten (circular), count stays RAS_DEPTH, RasOverflow set.
- Push with RetE same cycle: BranchE wins so no pop; push proceeds.
- Arithmetic: q+STEP modulo 2^WIDTH; wrap from all-ones region to low addresses is silent.
- Halt in RUN: on that edge q updates per normal rules, State→HALT; thereafter q frozen, ValidF=0, BranchE/RetE/CallE/StallF ignored, RAS unchanged.
- HALT: Resume → RUN on next edge, q unchanged on that edge. Halt and Resume both high in HALT: Resume wins. Resume in RUN/BOOT ignored.
- WatchHit: set on any edge in RUN where the newly loaded q equals WATCH_ADDR (increment or redirect); cleared only by reset.

## Timing
- All state updates on rising clk; reset asserts outputs immediately, release synchronous to next edge.
- Redirect latency 1 cycle: BranchE sampled at edge N → q=target after edge N.
- ValidF=1 exactly when State=RUN; combinational from State register.
- RasEmpty/RasFull reflect count after the most recent edge.
- Sticky flags rise 1 cycle after the causing edge is sampled, never fall without reset.

## Test plan
- Reset release, WIDTH=32, STEP=4, RESET_VEC=0, no stalls → BOOT one cycle with q=0, ValidF=0; then q=0,4,8,… with ValidF=1; WatchHit rises when q reaches 'h10.
- StallF high 3 cycles at q=8, then BranchE with target 'h100 while StallF still high → q holds 8 for stall cycles, then 'h100 next edge.
- Call/return: BranchE+CallE target 'h200, RetAddrE 'h40; later RetE → q='h200 then 'h40; RasEmpty back to 1.
- Five pushes with RAS_DEPTH=4 (ret addrs 'h10..'h50) → RasFull=1, RasOverflow=1; four RetE yield 'h50,'h40,'h30,'h20; fifth RetE → no redirect, RasUnderflow=1.
- Halt at q=8 → q=12 after that edge, then frozen with ValidF=0 while BranchE pulses; Resume → RUN, q=12 then 16.
- Async reset mid-cycle during halt with RAS full → q=RESET_VEC, State=BOOT, RAS empty, all sticky flags 0 immediately; STEP wrap check q='hFFFFFFFC → 0.
